decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of the saturating stall counter.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports pc_if and instr_if, each input 32, the fetch-stage PC and instruction.
REQ-005 SHALL have ports rs_data and rt_data, each input 32, register-file read data for rs_addr and rt_addr.
REQ-006 SHALL have port ex_mem_read  input  1  instruction in EX is a load.
REQ-007 SHALL have port ex_rt  input  5  load destination register in EX.
REQ-008 SHALL have port ex_reg_write  input  1  instruction in EX writes ex_dst.
REQ-009 SHALL have port ex_dst  input  5  EX destination register.
REQ-010 SHALL have port trap  input  1  trap request; flushes ID.
REQ-011 SHALL have port fetch_en  output  1  PC and IF/ID enable.
REQ-012 SHALL have ports jump_branch, jump_target and jump_reg, each output 1, redirect selects to fetch.
REQ-013 SHALL have port jr_pc  output  32  register jump target.
REQ-014 SHALL have ports pc_id output 32 (ID PC) and target_id output 26 (instr[25:0] of ID).
REQ-015 SHALL have ports rs_addr and rt_addr, each output 5, instr[25:21] and instr[20:16] of ID.
REQ-016 SHALL have ports valid_ex output 1, pc_ex output 32 and instr_ex output 32: the ID/EX pipeline register.
REQ-017 SHALL have port stall_count  output  STALL_CNT_W  saturating count of stall cycles.

Function
REQ-018 SHALL hold the IF/ID register (pc_id, instr_id, valid_id), loaded from pc_if/instr_if with valid_id=1 on cycles where fetch_en=1.
REQ-019 SHALL assert load-use stall when valid_id, ex_mem_read=1, ex_rt!=0 and ex_rt equals rs_addr, or ex_rt equals rt_addr.
REQ-020 SHALL assert branch stall when ID holds a branch or JR/JALR, valid_id, ex_reg_write=1, ex_dst!=0 and ex_dst matches a source register that the branch reads.
REQ-021 SHALL drive fetch_en = !(stall) with stall = load-use stall OR branch stall; trap overrides, and fetch_en=1 when trap=1.
REQ-022 On stall, SHALL hold IF/ID and load a bubble into ID/EX: valid_ex=0 and instr_ex=0.
REQ-023 Without stall, SHALL load ID/EX from IF/ID one cycle later: pc_ex=pc_id, instr_ex=instr_id and valid_ex=valid_id.
REQ-024 SHALL decode BEQ(4) and BNE(5) by comparing rs_data and rt_data.
REQ-025 SHALL decode BLEZ(6) and BGTZ(7) as signed rs_data tests.
REQ-026 SHALL decode REGIMM(1) as BLTZ when rt=0 and BGEZ when rt=1; other rt values are not branches.
REQ-027 SHALL assert jump_branch only when the branch condition is true.
REQ-028 SHALL assert jump_target for J(2) and JAL(3).
REQ-029 SHALL assert jump_reg for opcode 0 with funct 8 (JR) or funct 9 (JALR); jr_pc = rs_data.
REQ-030 SHALL assert jump_branch, jump_target and jump_reg only when valid_id=1, stall=0 and trap=0; at most one of them is asserted.
REQ-031 SHALL execute the branch delay slot: a redirect does not flush IF/ID.
REQ-032 On trap=1, SHALL clear valid_id and valid_ex on the next edge, regardless of stall.
REQ-033 SHALL increment stall_count by 1 for each cycle with stall=1 and trap=0, saturating at all-ones.
REQ-034 All redirect and stall outputs SHALL be combinational from the registered state and the current-cycle inputs; the IF/ID to ID/EX latency SHALL be 1 cycle.

Reset
REQ-035 While rst=1, on the clock edge SHALL clear pc_id, instr_id, valid_id, pc_ex, instr_ex, valid_ex and stall_count to 0.
REQ-036 An instruction in flight when rst rises SHALL be discarded with no redirect, since valid_id=0.
REQ-037 Reset SHALL take priority over trap and stall.

Structure
REQ-038 Opcode and funct constants (BEQ, BNE, BLEZ, BGTZ, REGIMM, J, JAL, JR, JALR) SHALL live in the shared MIPS defines package.
REQ-039 Pipeline registers SHALL reuse the codebase's existing enable/reset flip-flop cell.
REQ-040 One sub-module, branch_compare, SHALL compute the branch condition from the opcode, rt, rs_data and rt_data.

Verification
REQ-041 Load-use: ex_mem_read=1, ex_rt=8, ID=ADD rs=8 -> fetch_en=0 and valid_ex=0 for one cycle, then the ADD reaches EX; stall_count=1.
REQ-042 BEQ taken: rs_data=rt_data=5, pc_id=0x100 -> jump_branch=1 for one cycle; the delay-slot instruction at 0x104 reaches EX with valid_ex=1.
REQ-043 Trap during stall: stall active and trap=1 -> no jump_* outputs, fetch_en=1, and valid_id=valid_ex=0 on the next cycle.
REQ-044 JR after an ALU write: ex_reg_write=1, ex_dst=31, ID=JR $31 -> one stall cycle, then jump_reg=1 with jr_pc=rs_data.
REQ-045 Counter saturation: with STALL_CNT_W=4, hold stall for 20 cycles -> stall_count=15.
REQ-046 Register zero: ex_mem_read=1, ex_rt=0, ID reads $0 -> no stall.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_stage_pkg
// Shared MIPS defines: opcode / funct / REGIMM-rt constants used by the decode
// stage and its branch comparator, plus a small helper telling which source
// registers a conditional branch reads.
// -----------------------------------------------------------------------------
package decode_stage_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] OP_REGIMM  = 6'd1;
    localparam logic [5:0] OP_J       = 6'd2;
    localparam logic [5:0] OP_JAL     = 6'd3;
    localparam logic [5:0] OP_BEQ     = 6'd4;
    localparam logic [5:0] OP_BNE     = 6'd5;
    localparam logic [5:0] OP_BLEZ    = 6'd6;
    localparam logic [5:0] OP_BGTZ    = 6'd7;

    // SPECIAL funct codes (instr[5:0])
    localparam logic [5:0] FN_JR      = 6'd8;
    localparam logic [5:0] FN_JALR    = 6'd9;

    // REGIMM sub-opcodes carried in the rt field
    localparam logic [4:0] RT_BLTZ    = 5'd0;
    localparam logic [4:0] RT_BGEZ    = 5'd1;

    // Only the two-register compares read rt; every other branch reads rs only.
    function automatic logic branch_reads_rt(input logic [5:0] opcode);
        return (opcode == OP_BEQ) || (opcode == OP_BNE);
    endfunction

endpackage

// File: rtl/decode_stage_branch_compare.sv
// -----------------------------------------------------------------------------
// branch_compare
// Classifies the ID instruction as a conditional branch and evaluates its
// condition from the register-file read data.
// Ports:
//   opcode_i    - instr[31:26]
//   rt_i        - instr[20:16] (selects BLTZ/BGEZ under REGIMM)
//   rs_data_i   - rs read data
//   rt_data_i   - rt read data
//   is_branch_o - instruction is a conditional branch
//   taken_o     - branch condition holds (meaningful when is_branch_o=1)
// -----------------------------------------------------------------------------
module branch_compare
    import decode_stage_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [4:0]  rt_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic        is_branch_o,
    output logic        taken_o
);

    logic rs_neg;
    logic rs_zero;
    logic rs_eq_rt;

    assign rs_neg   = rs_data_i[31];
    assign rs_zero  = (rs_data_i == 32'd0);
    assign rs_eq_rt = (rs_data_i == rt_data_i);

    // NOTE: both outputs get a default before the case so no path through the
    // block leaves them unassigned (which would infer a latch).
    always_comb begin
        is_branch_o = 1'b1;
        taken_o     = 1'b0;
        case (opcode_i)
            OP_BEQ:  taken_o = rs_eq_rt;
            OP_BNE:  taken_o = !rs_eq_rt;
            OP_BLEZ: taken_o = rs_neg || rs_zero;
            OP_BGTZ: taken_o = !rs_neg && !rs_zero;
            OP_REGIMM: begin
                if (rt_i == RT_BLTZ) begin
                    taken_o = rs_neg;
                end else if (rt_i == RT_BGEZ) begin
                    taken_o = !rs_neg;
                end else begin
                    is_branch_o = 1'b0;
                end
            end
            default: is_branch_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/en_rst_ff.sv
// -----------------------------------------------------------------------------
// en_rst_ff
// Generic pipeline register cell: synchronous active-high clear, load enable.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous clear to zero, wins over en_i
//   en_i - load enable
//   d_i  - next value
//   q_o  - registered value
// -----------------------------------------------------------------------------
module en_rst_ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// MIPS ID stage: IF/ID and ID/EX pipeline registers, load-use and
// branch-operand hazard detection, branch/jump redirect decode with a
// delay slot, trap flush and a saturating stall-cycle counter.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   pc_if, instr_if           - fetch-stage PC and instruction
//   rs_data, rt_data          - register-file data for rs_addr / rt_addr
//   ex_mem_read, ex_rt        - EX holds a load writing ex_rt
//   ex_reg_write, ex_dst      - EX writes ex_dst
//   trap                      - flush ID and EX, forces fetch_en
//   fetch_en                  - PC and IF/ID enable
//   jump_branch/target/reg    - redirect selects to fetch
//   jr_pc                     - register jump target
//   pc_id, target_id          - ID PC and instr[25:0]
//   rs_addr, rt_addr          - ID source register numbers
//   valid_ex, pc_ex, instr_ex - ID/EX register
//   stall_count               - saturating count of stall cycles
// -----------------------------------------------------------------------------
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            pc_if,
    input  logic [31:0]            instr_if,
    input  logic [31:0]            rs_data,
    input  logic [31:0]            rt_data,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_rt,
    input  logic                   ex_reg_write,
    input  logic [4:0]             ex_dst,
    input  logic                   trap,
    output logic                   fetch_en,
    output logic                   jump_branch,
    output logic                   jump_target,
    output logic                   jump_reg,
    output logic [31:0]            jr_pc,
    output logic [31:0]            pc_id,
    output logic [25:0]            target_id,
    output logic [4:0]             rs_addr,
    output logic [4:0]             rt_addr,
    output logic                   valid_ex,
    output logic [31:0]            pc_ex,
    output logic [31:0]            instr_ex,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // Pipeline state
    logic [31:0]            pc_id_q,  instr_id_q;
    logic                   valid_id_q;
    logic [31:0]            pc_ex_q,  instr_ex_q;
    logic                   valid_ex_q;
    logic [STALL_CNT_W-1:0] stall_count_q;

    logic                   valid_id_d;
    logic [31:0]            instr_ex_d;
    logic                   valid_ex_d;
    logic [STALL_CNT_W-1:0] stall_count_d;
    logic                   stall_count_en;

    // ID decode
    logic [5:0] opcode, funct;
    logic [4:0] rs_a,   rt_a;
    logic       is_branch, br_taken, is_jr, is_jump;
    logic       reads_rs, reads_rt;
    logic       load_use_stall, branch_stall, stall, redirect_ok;

    assign opcode = instr_id_q[31:26];
    assign rs_a   = instr_id_q[25:21];
    assign rt_a   = instr_id_q[20:16];
    assign funct  = instr_id_q[5:0];

    branch_compare u_branch_compare (
        .opcode_i    (opcode),
        .rt_i        (rt_a),
        .rs_data_i   (rs_data),
        .rt_data_i   (rt_data),
        .is_branch_o (is_branch),
        .taken_o     (br_taken)
    );

    assign is_jr   = (opcode == OP_SPECIAL) && ((funct == FN_JR) || (funct == FN_JALR));
    assign is_jump = (opcode == OP_J) || (opcode == OP_JAL);

    // Operands a redirect resolves in ID; they cannot be forwarded from EX.
    assign reads_rs = is_branch || is_jr;
    assign reads_rt = is_branch && branch_reads_rt(opcode);

    assign load_use_stall = valid_id_q && ex_mem_read && (ex_rt != 5'd0) &&
                            ((ex_rt == rs_a) || (ex_rt == rt_a));

    assign branch_stall   = valid_id_q && ex_reg_write && (ex_dst != 5'd0) &&
                            ((reads_rs && (ex_dst == rs_a)) ||
                             (reads_rt && (ex_dst == rt_a)));

    assign stall       = load_use_stall || branch_stall;
    assign redirect_ok = valid_id_q && !stall && !trap;

    // Trap keeps fetch running so the handler address can be loaded.
    assign fetch_en    = trap || !stall;

    // Opcode classes are disjoint, so at most one redirect fires.
    assign jump_branch = redirect_ok && is_branch && br_taken;
    assign jump_target = redirect_ok && is_jump;
    assign jump_reg    = redirect_ok && is_jr;
    assign jr_pc       = rs_data;

    // IF/ID: a redirect does not flush it (delay slot); trap loads an
    // invalid slot.
    assign valid_id_d = !trap;

    en_rst_ff #(.WIDTH(65)) u_if_id (
        .clk  (clk),
        .rst  (rst),
        .en_i (fetch_en),
        .d_i  ({pc_if, instr_if, valid_id_d}),
        .q_o  ({pc_id_q, instr_id_q, valid_id_q})
    );

    // ID/EX: loads every cycle; a stall or trap inserts a bubble.
    assign instr_ex_d = stall ? 32'd0 : instr_id_q;
    assign valid_ex_d = valid_id_q && !stall && !trap;

    en_rst_ff #(.WIDTH(65)) u_id_ex (
        .clk  (clk),
        .rst  (rst),
        .en_i (1'b1),
        .d_i  ({pc_id_q, instr_ex_d, valid_ex_d}),
        .q_o  ({pc_ex_q, instr_ex_q, valid_ex_q})
    );

    // Stall counter: holds once all-ones; trap cycles are not counted.
    assign stall_count_d  = stall_count_q + STALL_CNT_W'(1);
    assign stall_count_en = stall && !trap && !(&stall_count_q);

    en_rst_ff #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .en_i (stall_count_en),
        .d_i  (stall_count_d),
        .q_o  (stall_count_q)
    );

    assign pc_id       = pc_id_q;
    assign target_id   = instr_id_q[25:0];
    assign rs_addr     = rs_a;
    assign rt_addr     = rt_a;
    assign valid_ex    = valid_ex_q;
    assign pc_ex       = pc_ex_q;
    assign instr_ex    = instr_ex_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage. Every instruction expected to reach EX
// as valid is queued when it is presented to fetch; a negedge monitor pops and
// compares whenever valid_ex is high. Scenario tasks check the combinational
// stall/redirect outputs inline.
// -----------------------------------------------------------------------------
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc_if, instr_if, rs_data, rt_data;
    logic          ex_mem_read, ex_reg_write, trap;
    logic [4:0]    ex_rt, ex_dst;
    logic          fetch_en, jump_branch, jump_target, jump_reg;
    logic [31:0]   jr_pc, pc_id;
    logic [25:0]   target_id;
    logic [4:0]    rs_addr, rt_addr;
    logic          valid_ex;
    logic [31:0]   pc_ex, instr_ex;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [2:0]  exp;   // {jump_branch, jump_target, jump_reg}
    } br_vec_t;

    decode_stage #(.STALL_CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_if        (pc_if),
        .instr_if     (instr_if),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .ex_reg_write (ex_reg_write),
        .ex_dst       (ex_dst),
        .trap         (trap),
        .fetch_en     (fetch_en),
        .jump_branch  (jump_branch),
        .jump_target  (jump_target),
        .jump_reg     (jump_reg),
        .jr_pc        (jr_pc),
        .pc_id        (pc_id),
        .target_id    (target_id),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .valid_ex     (valid_ex),
        .pc_ex        (pc_ex),
        .instr_ex     (instr_ex),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard monitor: every valid EX slot must match the oldest expectation.
    always @(negedge clk) begin
        if (valid_ex === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL ex_unexpected: got pc=%h instr=%h, want no valid instruction",
                         pc_ex, instr_ex);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({pc_ex, instr_ex} !== e)
                    $display("FAIL ex_order: got pc=%h instr=%h, want pc=%h instr=%h",
                             pc_ex, instr_ex, e[63:32], e[31:0]);
                else
                    n_pass++;
            end
        end
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_add(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'h0010};
    endfunction

    function automatic logic [31:0] enc_jr(input logic [4:0] rs, input logic [5:0] fn);
        return {6'd0, rs, 5'd0, 5'd0, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] instr, input bit push);
        pc_if    = pc;
        instr_if = instr;
        if (push) exp_q.push_back({pc, instr});
    endtask

    task automatic clear_ex();
        ex_mem_read  = 1'b0;
        ex_rt        = 5'd0;
        ex_reg_write = 1'b0;
        ex_dst       = 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_ex();
        trap     = 1'b0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        pc_if    = 32'd0;
        instr_if = 32'd0;
        step();
        step();
        exp_q.delete();
        rst = 1'b0;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (fetch_en !== 1'b1) $display("FAIL rst_fetch_en: got %b want 1", fetch_en);
        else n_pass++;
        n_checks++;
        if ({valid_ex, pc_ex, instr_ex} !== 65'd0)
            $display("FAIL rst_id_ex: got v=%b pc=%h instr=%h want all 0", valid_ex, pc_ex, instr_ex);
        else n_pass++;
        n_checks++;
        if ({pc_id, target_id} !== 58'd0)
            $display("FAIL rst_if_id: got pc=%h tgt=%h want 0", pc_id, target_id);
        else n_pass++;
        n_checks++;
        if (stall_count !== 4'd0) $display("FAIL rst_count: got %0d want 0", stall_count);
        else n_pass++;
        n_checks++;
        if ({jump_branch, jump_target, jump_reg} !== 3'b000)
            $display("FAIL rst_jumps: got %b want 000", {jump_branch, jump_target, jump_reg});
        else n_pass++;

        // JR in flight when reset rises is discarded without a redirect.
        rs_data = 32'h0000_1234;
        present(32'h200, enc_jr(5'd31, FN_JR), 1'b0);
        step();
        n_checks++;
        if (jump_reg !== 1'b1) $display("FAIL rst_jr_pre: got %b want 1", jump_reg);
        else n_pass++;
        rst = 1'b1;
        step();
        n_checks++;
        if ({jump_reg, valid_ex, pc_id} !== 34'd0)
            $display("FAIL rst_discard: got jr=%b v_ex=%b pc_id=%h want 0", jump_reg, valid_ex, pc_id);
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        present(32'h100, enc_add(5'd8, 5'd9, 5'd10), 1'b1);
        step();
        ex_mem_read = 1'b1;
        ex_rt       = 5'd8;
        present(32'h104, enc_add(5'd1, 5'd2, 5'd3), 1'b1);
        #1;
        n_checks++;
        if ({rs_addr, rt_addr} !== {5'd8, 5'd9})
            $display("FAIL lu_addrs: got rs=%0d rt=%0d want 8 9", rs_addr, rt_addr);
        else n_pass++;
        n_checks++;
        if (fetch_en !== 1'b0) $display("FAIL lu_fetch_en: got %b want 0", fetch_en);
        else n_pass++;
        step();
        n_checks++;
        if ({valid_ex, instr_ex} !== 33'd0)
            $display("FAIL lu_bubble: got v=%b instr=%h want 0", valid_ex, instr_ex);
        else n_pass++;
        n_checks++;
        if (pc_id !== 32'h100) $display("FAIL lu_hold: got pc_id=%h want 100", pc_id);
        else n_pass++;
        n_checks++;
        if (stall_count !== 4'd1) $display("FAIL lu_count: got %0d want 1", stall_count);
        else n_pass++;
        clear_ex();
        #1;
        n_checks++;
        if (fetch_en !== 1'b1) $display("FAIL lu_release: got %b want 1", fetch_en);
        else n_pass++;
        step();
        n_checks++;
        if ({valid_ex, pc_ex} !== {1'b1, 32'h100})
            $display("FAIL lu_issue: got v=%b pc=%h want 1 100", valid_ex, pc_ex);
        else n_pass++;
        present(32'h108, enc_add(5'd4, 5'd5, 5'd6), 1'b1);
        step();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 1) $display("FAIL lu_drain: got %0d queued want 1", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_beq_delay_slot();
        do_reset();
        present(32'h100, enc_i(OP_BEQ, 5'd1, 5'd2), 1'b1);
        step();
        rs_data = 32'd5;
        rt_data = 32'd5;
        present(32'h104, enc_add(5'd3, 5'd4, 5'd5), 1'b1);
        #1;
        n_checks++;
        if ({jump_branch, jump_target, jump_reg, fetch_en} !== 4'b1001)
            $display("FAIL beq_taken: got jb/jt/jr/fe=%b want 1001",
                     {jump_branch, jump_target, jump_reg, fetch_en});
        else n_pass++;
        n_checks++;
        if (target_id !== 26'({5'd1, 5'd2, 16'h0010}))
            $display("FAIL beq_target_id: got %h", target_id);
        else n_pass++;
        step();
        present(32'h200, enc_add(5'd6, 5'd7, 5'd8), 1'b1);
        #1;
        n_checks++;
        if (jump_branch !== 1'b0) $display("FAIL beq_one_cycle: got %b want 0", jump_branch);
        else n_pass++;
        step();
        n_checks++;
        if ({valid_ex, pc_ex} !== {1'b1, 32'h104})
            $display("FAIL beq_delay_slot: got v=%b pc=%h want 1 104", valid_ex, pc_ex);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 1) $display("FAIL beq_drain: got %0d queued want 1", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_redirect_table();
        br_vec_t tbl[$];
        tbl.push_back(br_vec_t'{enc_i(OP_BNE, 5'd1, 5'd2),      32'd7,         32'd7, 3'b000});
        tbl.push_back(br_vec_t'{enc_i(OP_BNE, 5'd1, 5'd2),      32'd7,         32'd8, 3'b100});
        tbl.push_back(br_vec_t'{enc_i(OP_BEQ, 5'd1, 5'd2),      32'd3,         32'd4, 3'b000});
        tbl.push_back(br_vec_t'{enc_i(OP_BLEZ, 5'd1, 5'd0),     32'd0,         32'd9, 3'b100});
        tbl.push_back(br_vec_t'{enc_i(OP_BLEZ, 5'd1, 5'd0),     32'd1,         32'd0, 3'b000});
        tbl.push_back(br_vec_t'{enc_i(OP_BLEZ, 5'd1, 5'd0),     32'h8000_0000, 32'd0, 3'b100});
        tbl.push_back(br_vec_t'{enc_i(OP_BGTZ, 5'd1, 5'd0),     32'd1,         32'd0, 3'b100});
        tbl.push_back(br_vec_t'{enc_i(OP_BGTZ, 5'd1, 5'd0),     32'd0,         32'd5, 3'b000});
        tbl.push_back(br_vec_t'{enc_i(OP_BGTZ, 5'd1, 5'd0),     32'hFFFF_FFFB, 32'd0, 3'b000});
        tbl.push_back(br_vec_t'{enc_i(OP_REGIMM, 5'd1, 5'd0),   32'hFFFF_FFFF, 32'd0, 3'b100});
        tbl.push_back(br_vec_t'{enc_i(OP_REGIMM, 5'd1, 5'd0),   32'd0,         32'd0, 3'b000});
        tbl.push_back(br_vec_t'{enc_i(OP_REGIMM, 5'd1, 5'd1),   32'd0,         32'd0, 3'b100});
        tbl.push_back(br_vec_t'{enc_i(OP_REGIMM, 5'd1, 5'd1),   32'h8000_0000, 32'd0, 3'b000});
        tbl.push_back(br_vec_t'{enc_i(OP_REGIMM, 5'd1, 5'd2),   32'hFFFF_FFFF, 32'd0, 3'b000});
        tbl.push_back(br_vec_t'{enc_i(OP_REGIMM, 5'd1, 5'd2),   32'd0,         32'd0, 3'b000});
        tbl.push_back(br_vec_t'{enc_j(OP_J,   26'h0ABCDEF),     32'd0,         32'd0, 3'b010});
        tbl.push_back(br_vec_t'{enc_j(OP_JAL, 26'h0000040),     32'd0,         32'd0, 3'b010});
        tbl.push_back(br_vec_t'{enc_jr(5'd5, FN_JR),            32'h0040_0020, 32'd0, 3'b001});
        tbl.push_back(br_vec_t'{enc_jr(5'd6, FN_JALR),          32'h1000_0100, 32'd0, 3'b001});
        tbl.push_back(br_vec_t'{enc_add(5'd1, 5'd2, 5'd3),      32'd1,         32'd1, 3'b000});

        do_reset();
        present(32'h1000, tbl[0].instr, 1'b1);
        step();
        for (int i = 0; i < tbl.size(); i++) begin
            rs_data = tbl[i].rs_d;
            rt_data = tbl[i].rt_d;
            if (i + 1 < tbl.size()) present(32'h1000 + 32'(4 * (i + 1)), tbl[i + 1].instr, 1'b1);
            else                    present(32'h2000, enc_add(5'd0, 5'd0, 5'd0), 1'b1);
            #1;
            n_checks++;
            if ({jump_branch, jump_target, jump_reg} !== tbl[i].exp)
                $display("FAIL redirect[%0d]: instr=%h got jb/jt/jr=%b want %b", i, tbl[i].instr,
                         {jump_branch, jump_target, jump_reg}, tbl[i].exp);
            else n_pass++;
            if (tbl[i].exp[0]) begin
                n_checks++;
                if (jr_pc !== tbl[i].rs_d)
                    $display("FAIL jr_pc[%0d]: got %h want %h", i, jr_pc, tbl[i].rs_d);
                else n_pass++;
            end
            step();
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 1) $display("FAIL tbl_drain: got %0d queued want 1", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_trap_during_stall();
        do_reset();
        present(32'h300, enc_i(OP_BEQ, 5'd8, 5'd9), 1'b0);
        step();
        rs_data     = 32'd3;
        rt_data     = 32'd3;
        ex_mem_read = 1'b1;
        ex_rt       = 5'd8;
        present(32'h304, enc_j(OP_J, 26'h0000100), 1'b0);
        #1;
        n_checks++;
        if (fetch_en !== 1'b0) $display("FAIL trap_pre_stall: got %b want 0", fetch_en);
        else n_pass++;
        trap = 1'b1;
        #1;
        n_checks++;
        if ({jump_branch, jump_target, jump_reg, fetch_en} !== 4'b0001)
            $display("FAIL trap_override: got jb/jt/jr/fe=%b want 0001",
                     {jump_branch, jump_target, jump_reg, fetch_en});
        else n_pass++;
        step();
        trap = 1'b0;
        clear_ex();
        present(32'h308, enc_add(5'd1, 5'd1, 5'd1), 1'b1);
        #1;
        n_checks++;
        if ({valid_ex, jump_target, pc_id} !== {2'b00, 32'h304})
            $display("FAIL trap_flush: got v_ex=%b jt=%b pc_id=%h want 0 0 304",
                     valid_ex, jump_target, pc_id);
        else n_pass++;
        n_checks++;
        if (stall_count !== 4'd0) $display("FAIL trap_count: got %0d want 0", stall_count);
        else n_pass++;
        step();
        n_checks++;
        if (valid_ex !== 1'b0) $display("FAIL trap_ex_clear: got %b want 0", valid_ex);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 1) $display("FAIL trap_drain: got %0d queued want 1", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_jr_after_alu();
        do_reset();
        present(32'h400, enc_jr(5'd31, FN_JR), 1'b1);
        step();
        rs_data      = 32'hDEAD_BEEC;
        ex_reg_write = 1'b1;
        ex_dst       = 5'd31;
        present(32'h404, enc_add(5'd2, 5'd3, 5'd4), 1'b1);
        #1;
        n_checks++;
        if ({fetch_en, jump_reg} !== 2'b00)
            $display("FAIL jr_stall: got fe=%b jr=%b want 0 0", fetch_en, jump_reg);
        else n_pass++;
        step();
        clear_ex();
        #1;
        n_checks++;
        if ({valid_ex, stall_count} !== {1'b0, 4'd1})
            $display("FAIL jr_bubble: got v=%b cnt=%0d want 0 1", valid_ex, stall_count);
        else n_pass++;
        n_checks++;
        if ({jump_reg, fetch_en, jr_pc} !== {2'b11, 32'hDEAD_BEEC})
            $display("FAIL jr_fire: got jr=%b fe=%b jr_pc=%h want 1 1 deadbeec",
                     jump_reg, fetch_en, jr_pc);
        else n_pass++;
        step();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 1) $display("FAIL jr_drain: got %0d queued want 1", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_hazard_boundaries();
        do_reset();
        present(32'h500, enc_add(5'd0, 5'd9, 5'd3), 1'b1);
        step();
        ex_mem_read = 1'b1;
        ex_rt       = 5'd0;
        #1;
        n_checks++;
        if (fetch_en !== 1'b1) $display("FAIL zero_reg: got %b want 1", fetch_en);
        else n_pass++;
        ex_rt = 5'd9;
        #1;
        n_checks++;
        if (fetch_en !== 1'b0) $display("FAIL lu_rt_match: got %b want 0", fetch_en);
        else n_pass++;
        ex_mem_read = 1'b0;
        #1;
        n_checks++;
        if (fetch_en !== 1'b1) $display("FAIL lu_no_load: got %b want 1", fetch_en);
        else n_pass++;
        ex_reg_write = 1'b1;
        ex_dst       = 5'd9;
        #1;
        n_checks++;
        if (fetch_en !== 1'b1) $display("FAIL alu_non_branch: got %b want 1", fetch_en);
        else n_pass++;
        clear_ex();
        present(32'h504, enc_i(OP_REGIMM, 5'd4, 5'd1), 1'b1);
        step();
        rs_data      = 32'd0;
        ex_reg_write = 1'b1;
        ex_dst       = 5'd1;
        present(32'h508, enc_add(5'd0, 5'd0, 5'd0), 1'b1);
        #1;
        n_checks++;
        if ({fetch_en, jump_branch} !== 2'b11)
            $display("FAIL bgez_rt_unread: got fe=%b jb=%b want 1 1", fetch_en, jump_branch);
        else n_pass++;
        ex_dst = 5'd4;
        #1;
        n_checks++;
        if ({fetch_en, jump_branch} !== 2'b00)
            $display("FAIL bgez_rs_hazard: got fe=%b jb=%b want 0 0", fetch_en, jump_branch);
        else n_pass++;
        clear_ex();
        step();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 1) $display("FAIL hz_drain: got %0d queued want 1", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        present(32'h600, enc_add(5'd8, 5'd1, 5'd2), 1'b1);
        step();
        ex_mem_read = 1'b1;
        ex_rt       = 5'd8;
        present(32'h604, enc_add(5'd3, 5'd3, 5'd3), 1'b1);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) begin
                n_checks++;
                if (stall_count !== 4'd14) $display("FAIL sat_mid: got %0d want 14", stall_count);
                else n_pass++;
            end
        end
        n_checks++;
        if ({stall_count, fetch_en} !== {4'd15, 1'b0})
            $display("FAIL sat_final: got cnt=%0d fe=%b want 15 0", stall_count, fetch_en);
        else n_pass++;
        clear_ex();
        step();
        n_checks++;
        if ({valid_ex, pc_ex, stall_count} !== {1'b1, 32'h600, 4'd15})
            $display("FAIL sat_issue: got v=%b pc=%h cnt=%0d want 1 600 15", valid_ex, pc_ex, stall_count);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 1) $display("FAIL sat_drain: got %0d queued want 1", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            // ALU ops only; no hazard inputs are active, so nothing may stall.
            present(32'h700 + 32'(4 * i),
                    enc_add(5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31))),
                    1'b1);
            #1;
            n_checks++;
            if (fetch_en !== 1'b1) $display("FAIL b2b_fetch[%0d]: got %b want 1", i, fetch_en);
            else n_pass++;
            step();
        end
        present(32'h800, enc_add(5'd0, 5'd0, 5'd0), 1'b1);
        step();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 1) $display("FAIL b2b_drain: got %0d queued want 1", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        clear_ex();
        trap     = 1'b0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        pc_if    = 32'd0;
        instr_if = 32'd0;

        test_reset();
        test_load_use();
        test_beq_delay_slot();
        test_redirect_table();
        test_trap_during_stall();
        test_jr_after_alu();
        test_hazard_boundaries();
        test_saturation();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
